// File: rtl/hack_mul_seq.sv
`default_nettype none
// =============================================================================
// Module   : hack_mul_seq
// Brief    : 16x16 shift-and-add multiplier; every addition goes through an
//            external Hack ALU, so this block holds only registers and muxes.
// Revision : 1.0
// =============================================================================
module hack_mul_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic        product_zr,
    output logic        product_ng,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic [5:0]  alu_op,
    input  logic [15:0] alu_out
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DBL  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [5:0] OP_ZERO = 6'b101010;
    localparam logic [5:0] OP_ADD  = 6'b000010;

    logic [1:0]  r_state;
    logic [15:0] r_acc;
    logic [15:0] r_mcand;
    logic [15:0] r_mplier;
    logic [15:0] w_mplier_shr;

    assign w_mplier_shr = {1'b0, r_mplier[15:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_acc    <= 16'h0000;
            r_mcand  <= 16'h0000;
            r_mplier <= 16'h0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_acc    <= 16'h0000;
                        r_mcand  <= a;
                        r_mplier <= b;
                        r_state  <= (b == 16'h0000) ? ST_DONE : ST_ADD;
                    end
                end
                ST_ADD: begin
                    if (r_mplier[0]) begin
                        r_acc <= alu_out;
                    end
                    r_state <= ST_DBL;
                end
                ST_DBL: begin
                    // The ALU computes mcand + mcand here, i.e. a left shift.
                    r_mcand  <= alu_out;
                    r_mplier <= w_mplier_shr;
                    r_state  <= (w_mplier_shr == 16'h0000) ? ST_DONE : ST_ADD;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        alu_x  = r_acc;
        alu_y  = 16'h0000;
        alu_op = OP_ZERO;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            ST_ADD: begin
                alu_x  = r_acc;
                alu_y  = r_mcand;
                alu_op = OP_ADD;
                busy   = 1'b1;
            end
            ST_DBL: begin
                alu_x  = r_mcand;
                alu_y  = r_mcand;
                alu_op = OP_ADD;
                busy   = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                alu_op = OP_ZERO;
            end
        endcase
    end

    assign product    = r_acc;
    assign product_zr = (r_acc == 16'h0000);
    assign product_ng = r_acc[15];

endmodule
`default_nettype wire

// File: tb/tb_hack_mul_seq.sv
`default_nettype none
// =============================================================================
// Module   : tb_hack_mul_seq
// Brief    : Scoreboard bench for hack_mul_seq with a golden Hack ALU model.
// Revision : 1.0
// =============================================================================
module tb_hack_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        product_zr;
    logic        product_ng;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [5:0]  alu_op;
    logic [15:0] alu_out;

    always #5 clk = ~clk;

    hack_mul_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .product    (product),
        .product_zr (product_zr),
        .product_ng (product_ng),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_op     (alu_op),
        .alu_out    (alu_out)
    );

    function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                             input logic [5:0] op);
        logic [15:0] xx;
        logic [15:0] yy;
        logic [15:0] o;
        xx = op[5] ? 16'h0000 : x;
        if (op[4]) xx = ~xx;
        yy = op[3] ? 16'h0000 : y;
        if (op[2]) yy = ~yy;
        o = op[1] ? (xx + yy) : (xx & yy);
        if (op[0]) o = ~o;
        return o;
    endfunction

    always_comb alu_out = hack_alu(alu_x, alu_y, alu_op);

    typedef struct {
        logic [15:0] prod;
        int          acc_cyc;
        int          lat;
    } res_t;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
    } alu_t;

    res_t res_q[$];
    alu_t alu_q[$];

    int          cyc = 0;
    int          checks = 0;
    int          passes = 0;
    bit          mon_en = 1'b0;
    logic [15:0] last_prod = 16'h0000;
    res_t        mon_r;
    alu_t        mon_e;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every busy cycle consumes one expected ALU step, every done one result.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (busy) begin
                if (alu_q.size() == 0) begin
                    check("busy_unexpected", {31'd0, busy}, 32'd0);
                end else begin
                    mon_e = alu_q.pop_front();
                    check("alu_op", {26'd0, alu_op}, {26'd0, 6'b000010});
                    check("alu_x", {16'd0, alu_x}, {16'd0, mon_e.x});
                    check("alu_y", {16'd0, alu_y}, {16'd0, mon_e.y});
                end
            end
            if (done) begin
                check("busy_in_done", {31'd0, busy}, 32'd0);
                if (res_q.size() == 0) begin
                    check("spurious_done", {31'd0, done}, 32'd0);
                end else begin
                    mon_r = res_q.pop_front();
                    check("product", {16'd0, product}, {16'd0, mon_r.prod});
                    check("product_zr", {31'd0, product_zr}, {31'd0, (mon_r.prod == 16'h0000)});
                    check("product_ng", {31'd0, product_ng}, {31'd0, mon_r.prod[15]});
                    check("latency", cyc - mon_r.acc_cyc, mon_r.lat);
                    check("alu_op_done", {26'd0, alu_op}, {26'd0, 6'b101010});
                    check("alu_steps_left", alu_q.size(), 32'd0);
                    last_prod = mon_r.prod;
                end
            end else if (!busy) begin
                check("product_hold", {16'd0, product}, {16'd0, last_prod});
            end
        end
    end

    // Expected behaviour derived from long multiplication on the bits of b.
    task automatic push_model(input logic [15:0] av, input logic [15:0] bv);
        int          k;
        logic [15:0] partial;
        logic [15:0] ai;
        res_t        r;
        k = 0;
        for (int i = 0; i < 16; i++) if (bv[i]) k = i + 1;
        partial = 16'h0000;
        for (int i = 0; i < k; i++) begin
            ai = av << i;
            alu_q.push_back('{x: partial, y: ai});
            alu_q.push_back('{x: ai, y: ai});
            if (bv[i]) partial = partial + ai;
        end
        r.prod    = av * bv;
        r.acc_cyc = cyc + 1;
        r.lat     = 2 * k;
        res_q.push_back(r);
    endtask

    task automatic issue(input logic [15:0] av, input logic [15:0] bv, input bit inject);
        int n;
        @(negedge clk);
        push_model(av, bv);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        n = 0;
        while (!done && n < 40) begin
            if (inject && n == 4) begin
                start = 1'b1;
                a     = 16'h7777;
                b     = 16'h0003;
            end
            if (inject && n == 6) start = 1'b0;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (!done) begin
            check("done_timeout", 32'd0, 32'd1);
            res_q.delete();
            alu_q.delete();
        end
    endtask

    initial begin
        int w;
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_product", {16'd0, product}, 32'd0);
        check("rst_zr", {31'd0, product_zr}, 32'd1);
        check("rst_ng", {31'd0, product_ng}, 32'd0);
        check("rst_alu_op", {26'd0, alu_op}, {26'd0, 6'b101010});
        check("rst_alu_xy", {alu_x, alu_y}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        mon_en = 1'b1;

        issue(16'd3, 16'd5, 1'b0);
        issue(16'h1234, 16'h0000, 1'b0);
        issue(16'hFFFF, 16'd7, 1'b0);
        issue(16'h0100, 16'h0100, 1'b0);
        issue(16'h0001, 16'h8000, 1'b1);
        repeat (40) @(negedge clk);

        // Abort a=5, b=9 while the first doubling step is in progress.
        mon_en = 1'b0;
        @(negedge clk);
        start = 1'b1;
        a     = 16'd5;
        b     = 16'd9;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("busy_before_abort", {31'd0, busy}, 32'd1);
        check("dbl_alu_x", {16'd0, alu_x}, 32'd5);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_product", {16'd0, product}, 32'd0);
        check("abort_zr", {31'd0, product_zr}, 32'd1);
        check("abort_alu_op", {26'd0, alu_op}, {26'd0, 6'b101010});
        check("abort_alu_xy", {alu_x, alu_y}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        last_prod = 16'h0000;
        mon_en = 1'b1;
        issue(16'd2, 16'd3, 1'b0);

        for (int t = 0; t < 40; t++) begin
            w = $urandom_range(0, 16);
            issue(16'($urandom), 16'($urandom & ((32'd1 << w) - 32'd1)), 1'b0);
        end

        repeat (5) @(negedge clk);
        check("results_left", res_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
